x_memxbar_ord: RTL

Parametrised single-master to N-context memory crossbar with in-order read completion. It sits between the main memory request port and the per-chip 23K640 context controllers. It decodes each main request to one context, forwards it with the context-local address, and tracks outstanding reads. Read data always returns to main in issue order, even when contexts complete out of order.

---
 rtl/x_memxbar_ord.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/x_memxbar_ord.sv
// Single-master to NUM_CTX memory crossbar: decodes main requests to one context
// and returns read data to main strictly in issue order via an order FIFO.
module x_memxbar_ord #(
    parameter int unsigned NUM_CTX    = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CTX_ADDR_W = 13,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned INTERLEAVE = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_main_valid,
    output logic                         o_main_accept,
    input  logic                         i_main_rd_n_wr,
    input  logic [ADDR_W-1:0]            i_main_addr,
    input  logic [DATA_W-1:0]            i_main_wdata,
    output logic                         o_main_ready,
    output logic [DATA_W-1:0]            o_main_rdata,
    output logic [NUM_CTX-1:0]           o_ctx_valid,
    input  logic [NUM_CTX-1:0]           i_ctx_accept,
    output logic [NUM_CTX-1:0]           o_ctx_rd_n_wr,
    output logic [NUM_CTX*CTX_ADDR_W-1:0] o_ctx_addr,
    output logic [NUM_CTX*DATA_W-1:0]    o_ctx_wdata,
    input  logic [NUM_CTX-1:0]           i_ctx_ready,
    input  logic [NUM_CTX*DATA_W-1:0]    i_ctx_rdata
);

    localparam int unsigned IDX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam int unsigned LOG_N = $clog2(NUM_CTX);
    localparam int unsigned AW_P  = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW_P + 1;
    localparam int unsigned ENT_W = IDX_W + 1;

    logic [ADDR_W-1:0]     idx_full;
    logic [CTX_ADDR_W-1:0] local_addr;
    logic [IDX_W-1:0]      idx;
    logic                  mapped;
    logic                  is_rd;
    logic                  busy_sel;
    logic                  acc_sel;
    logic                  blk;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic [ENT_W-1:0]      fifo_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [NUM_CTX-1:0]    busy_q, busy_d;
    logic [NUM_CTX-1:0]    held_q, held_d;
    logic [DATA_W-1:0]     hdata_q [NUM_CTX];
    logic [DATA_W-1:0]     hdata_d [NUM_CTX];
    logic                  main_ready_q, main_ready_d;
    logic [DATA_W-1:0]     main_rdata_q, main_rdata_d;

    logic [ENT_W-1:0]      head;
    logic                  head_unm;
    logic [IDX_W-1:0]      head_idx;
    logic                  head_held;
    logic [DATA_W-1:0]     head_data;
    logic [NUM_CTX-1:0]    cap;
    logic [NUM_CTX-1:0]    set_mask;
    logic [NUM_CTX-1:0]    clr_mask;

    // Address decode: pick context index and context-local address
    always_comb begin
        idx_full   = '0;
        local_addr = '0;
        if (INTERLEAVE != 0) begin
            idx_full   = i_main_addr & ADDR_W'(NUM_CTX - 1);
            local_addr = CTX_ADDR_W'(i_main_addr >> LOG_N);
        end else begin
            idx_full   = i_main_addr >> CTX_ADDR_W;
            local_addr = CTX_ADDR_W'(i_main_addr);
        end
        mapped = (idx_full < ADDR_W'(NUM_CTX));
        idx    = IDX_W'(idx_full);
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW_P-1:0] == rd_ptr_q[AW_P-1:0]) &&
                        (wr_ptr_q[AW_P] != rd_ptr_q[AW_P]);

    // Request path: broadcast payload, qualify valid, derive accept
    always_comb begin
        is_rd         = i_main_rd_n_wr;
        busy_sel      = 1'b0;
        acc_sel       = 1'b0;
        o_ctx_valid   = '0;
        o_ctx_rd_n_wr = '0;
        o_ctx_addr    = '0;
        o_ctx_wdata   = '0;
        for (int k = 0; k < NUM_CTX; k++) begin
            if (idx == IDX_W'(k)) begin
                busy_sel = busy_q[k];
                acc_sel  = i_ctx_accept[k];
            end
        end
        // Reads stall on a full order FIFO or an already-busy context
        blk = is_rd & (fifo_full | (mapped & busy_sel));
        for (int k = 0; k < NUM_CTX; k++) begin
            o_ctx_valid[k]                              = i_main_valid & mapped &
                                                          (idx == IDX_W'(k)) & ~blk;
            o_ctx_rd_n_wr[k]                            = is_rd;
            o_ctx_addr[k*CTX_ADDR_W +: CTX_ADDR_W]      = local_addr;
            o_ctx_wdata[k*DATA_W +: DATA_W]             = i_main_wdata;
        end
        if (mapped) begin
            o_main_accept = i_main_valid & ~blk & acc_sel;
        end else begin
            o_main_accept = i_main_valid & ~(is_rd & fifo_full);
        end
        push = o_main_accept & is_rd;
    end

    // Completion: pop the head once its data is held (or it is unmapped)
    always_comb begin
        head      = fifo_q[rd_ptr_q[AW_P-1:0]];
        head_unm  = head[IDX_W];
        head_idx  = head[IDX_W-1:0];
        head_held = 1'b0;
        head_data = '0;
        for (int k = 0; k < NUM_CTX; k++) begin
            if (head_idx == IDX_W'(k)) begin
                head_held = held_q[k];
                head_data = hdata_q[k];
            end
        end
        pop = ~fifo_empty & (head_unm | head_held);

        for (int k = 0; k < NUM_CTX; k++) begin
            set_mask[k] = push & mapped & (idx == IDX_W'(k));
            clr_mask[k] = pop & ~head_unm & (head_idx == IDX_W'(k));
            cap[k]      = i_ctx_ready[k] & busy_q[k];
            hdata_d[k]  = cap[k] ? i_ctx_rdata[k*DATA_W +: DATA_W] : hdata_q[k];
        end
        busy_d = (busy_q | set_mask) & ~clr_mask;
        held_d = (held_q | cap) & ~clr_mask;

        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        main_ready_d = pop;
        main_rdata_d = '0;
        if (pop) begin
            main_rdata_d = head_unm ? '1 : head_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            busy_q       <= '0;
            held_q       <= '0;
            main_ready_q <= 1'b0;
            main_rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            for (int k = 0; k < NUM_CTX; k++) begin
                hdata_q[k] <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            busy_q       <= busy_d;
            held_q       <= held_d;
            main_ready_q <= main_ready_d;
            main_rdata_q <= main_rdata_d;
            if (push) begin
                fifo_q[wr_ptr_q[AW_P-1:0]] <= {~mapped, idx};
            end
            for (int k = 0; k < NUM_CTX; k++) begin
                hdata_q[k] <= hdata_d[k];
            end
        end
    end

    assign o_main_ready = main_ready_q;
    assign o_main_rdata = main_rdata_q;

endmodule
